instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the single-cycle RISC-V core. Takes the current `PCaddr` from the PC block and runs a read request on the instruction-memory port. It latches the returned word and pulses `iready` for one cycle, which tells the PC block to advance. Sits between the PC register and the decoder/control unit.

## Interface
- `RESET_INSTR`, 32'h0000_0013: instruction presented while no fetch has completed (addi x0,x0,0 NOP).
- `clk` input 1: system clock, rising-edge.
- `nRST` input 1: asynchronous reset, active-low.
- `PCaddr` input 32: fetch address from the PC block.
- `dstall` input 1: the data port holds the shared memory bus; a new fetch must not start.
- `flush` input 1: invalidates the reuse buffer; ignored without `FETCH_REUSE_EN`.
- `mem_ren` output 1: instruction read request to the memory handler.
- `mem_addr` output 32: read address, `{addr_q[31:2], 2'b00}`.
- `mem_rdata` input 32: read data, valid in a cycle where `mem_ren`=1 and `mem_busy`=0.
- `mem_busy` input 1: memory not ready; the request is held.
- `instr` output 32: last fetched instruction; stable between fetches.
- `iready` output 1: one-cycle pulse; `instr` is new and the PC may update on this edge.
- `misalign` output 1: the last fetch address had `PCaddr[1:0]`≠0.

## Operation
- The FSM has four states: `IDLE`, `REQ`, `WAIT` and `DONE`.
- **IDLE**: `mem_ren`=0. If `dstall`=1, stay in IDLE. Otherwise:
  - `addr_q <= PCaddr`.
  - If `PCaddr[1:0]`≠0: `instr <= RESET_INSTR`, `misalign <= 1`, go to DONE.
  - Otherwise: `misalign <= 0`, go to REQ.
- **REQ**: `mem_ren`=1, `mem_addr` from `addr_q`. Go to WAIT unconditionally.
- **WAIT**: `mem_ren`=1. If `mem_busy`=1, stay in WAIT. If `mem_busy`=0: `instr <= mem_rdata`, go to DONE.
- **DONE**: `iready`=1 and `mem_ren`=0. Go to IDLE.
- `addr_q` is sampled only in IDLE. `PCaddr` changes during REQ/WAIT/DONE are ignored.
- `dstall` is sampled only in IDLE. An in-flight fetch always completes.
- `instr` changes only on the edge that enters DONE. It holds through IDLE, REQ and WAIT.
- `iready` is a registered-state decode (`state==DONE`), so it is never combinationally dependent on inputs.

## Timing
- **Reset values**: state=IDLE, `instr`=`RESET_INSTR`, `iready`=0, `mem_ren`=0, `mem_addr`=0, `misalign`=0, `addr_q`=0, reuse valid=0.
- **Reset mid-fetch**: state returns to IDLE at once and `mem_ren` drops asynchronously. A memory response arriving after reset is ignored.
- **Latency**: `PCaddr` sampled in IDLE at cycle 0 → REQ in cycle 1 → WAIT in cycle 2 → DONE (`iready`=1) in cycle 3 when `mem_busy`=0 in cycle 2. Each cycle of `mem_busy`=1 in WAIT adds one cycle.
- **Misaligned fetch**: `iready` in cycle 1, and `mem_ren` never asserts.
- **Throughput**: back-to-back fetches start every 4 cycles, because DONE always passes through IDLE.
- **`flush` in the same cycle as a reuse hit**: `flush` wins, so there is no hit and a bus fetch is performed.

## Configuration
- `FETCH_REUSE_EN` defined:
  - Adds a one-entry reuse buffer (`tag_addr`, `tag_data`, `tag_valid`).
  - Every completed bus fetch loads the buffer with `addr_q`/`mem_rdata` and sets `tag_valid`.
  - In IDLE with `dstall`=0, if `tag_valid` and `PCaddr`==`tag_addr` and `flush`=0: `instr <= tag_data` and go directly to DONE. `iready` then follows in cycle 1 with no bus access.
  - `flush`=1 clears `tag_valid` in any state. Misaligned fetches never load the buffer.
- `FETCH_REUSE_EN` undefined: no buffer, `flush` is unused, and every aligned fetch uses the bus.

## Test plan
- **Reset**: assert `nRST`=0 → `instr`=32'h0000_0013, `iready`=0, `mem_ren`=0. Release with `PCaddr`=0, `mem_busy`=0, `mem_rdata`=32'h0050_0093 → `mem_ren`=1 in cycles 1–2, `instr`=32'h0050_0093 and `iready`=1 in cycle 3.
- **Wait states**: `PCaddr`=32'h0000_0004, `mem_busy`=1 for 5 cycles of WAIT → `iready` in cycle 8. `mem_addr`=32'h0000_0004 throughout, and a `PCaddr` change mid-fetch has no effect.
- **Stall**: `dstall`=1 for 3 cycles in IDLE → `mem_ren` stays 0. The fetch starts on the first cycle with `dstall`=0. Asserting `dstall` during WAIT does not abort the fetch.
- **Misaligned**: `PCaddr`=32'h0000_0006 → `misalign`=1, `instr`=32'h0000_0013, `iready` in cycle 1, `mem_ren` never asserted.
- **Reset mid-fetch**: `nRST`=0 during WAIT → `mem_ren`=0 immediately, and the next fetch after release restarts from IDLE.
- **Reuse (`FETCH_REUSE_EN`)**: fetch 32'h0000_0010 twice → the second fetch has `iready` in cycle 1 with no `mem_ren`. The same address after `flush`=1 → full bus fetch, `iready` in cycle 3.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage of the single-cycle RISC-V core.
// Samples PCaddr in IDLE and issues one read on the instruction-memory port.
// It latches the returned word and pulses iready for one cycle so that the
// PC block can advance.
// Optional feature: define FETCH_REUSE_EN to add a one-entry reuse buffer.
// The buffer serves a repeated fetch address without using the bus.
module instr_fetch #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] PCaddr,
  input  logic        dstall,
  input  logic        flush,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic [31:0] instr,
  output logic        iready,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] addr_reg;
  logic [31:0] instr_reg;
  logic        misalign_reg;

  logic        start_fetch;
  logic        pc_misaligned;
  logic        bus_done;
  logic        reuse_hit;
  logic [31:0] reuse_data;

  // A new fetch may begin only from IDLE while the data port leaves the bus free.
  assign start_fetch   = (state_reg == IDLE) && !dstall;
  assign pc_misaligned = (PCaddr[1:0] != 2'b00);
  // The memory word is valid on the cycle that WAIT sees mem_busy low.
  assign bus_done      = (state_reg == WAIT) && !mem_busy;

`ifdef FETCH_REUSE_EN
  logic [31:0] tag_addr_reg;
  logic [31:0] tag_data_reg;
  logic        tag_valid_reg;

  // flush in the same cycle suppresses a hit, which forces a real bus fetch.
  assign reuse_hit  = tag_valid_reg && (PCaddr == tag_addr_reg) && !flush;
  assign reuse_data = tag_data_reg;

  // Reuse buffer: capture every completed bus fetch; flush invalidates it in any state.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tag_addr_reg  <= 32'h0;
      tag_data_reg  <= 32'h0;
      tag_valid_reg <= 1'b0;
    end else begin
      if (bus_done) begin
        tag_addr_reg <= addr_reg;
        tag_data_reg <= mem_rdata;
      end
      if (flush) begin
        tag_valid_reg <= 1'b0;
      end else if (bus_done) begin
        tag_valid_reg <= 1'b1;
      end
    end
  end
`else
  logic unused_inputs;

  assign reuse_hit     = 1'b0;
  assign reuse_data    = 32'h0;
  // Without the buffer, flush and the byte-offset bits of the address have no consumer.
  assign unused_inputs = ^{flush, addr_reg[1:0]};
`endif

  // State register; reset drops back to IDLE asynchronously, abandoning any fetch.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: misaligned and reuse-hit fetches skip the bus and go straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!dstall) begin
          if (pc_misaligned || reuse_hit) begin
            state_next = DONE;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ:     state_next = WAIT;
      WAIT: begin
        if (!mem_busy) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state only, so no output depends on inputs combinationally.
  always_comb begin
    mem_ren = 1'b0;
    iready  = 1'b0;
    case (state_reg)
      REQ:     mem_ren = 1'b1;
      WAIT:    mem_ren = 1'b1;
      DONE:    iready  = 1'b1;
      default: begin
        mem_ren = 1'b0;
        iready  = 1'b0;
      end
    endcase
  end

  // Fetch datapath: the address is captured only when a fetch starts; instr changes only on entry to DONE.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      addr_reg     <= 32'h0;
      instr_reg    <= RESET_INSTR;
      misalign_reg <= 1'b0;
    end else begin
      if (start_fetch) begin
        addr_reg <= PCaddr;
        if (pc_misaligned) begin
          instr_reg    <= RESET_INSTR;
          misalign_reg <= 1'b1;
        end else begin
          misalign_reg <= 1'b0;
          if (reuse_hit) begin
            instr_reg <= reuse_data;
          end
        end
      end else if (bus_done) begin
        instr_reg <= mem_rdata;
      end
    end
  end

  assign mem_addr = {addr_reg[31:2], 2'b00};
  assign instr    = instr_reg;
  assign misalign = misalign_reg;

endmodule
